// File: rtl/dl1_data_cache.sv
// dl1_data_cache: direct-mapped, write-back, write-allocate L1 data cache with L2 refill/victim ports.
// Define DL1_SNOOP_INVALIDATE_EN to add the replace_req/replace_addr snoop-invalidate port.
module dl1_data_cache #(
  parameter int DATA_LENGTH    = 32,
  parameter int DL1_LINES      = 64,
  parameter int WORDS_PER_LINE = 4,
  localparam int WORD_W   = $clog2(WORDS_PER_LINE),
  localparam int INDEX_W  = $clog2(DL1_LINES),
  localparam int OFFSET_W = WORD_W + 2,
  localparam int TAG_W    = DATA_LENGTH - INDEX_W - OFFSET_W,
  localparam int LINE_W   = DATA_LENGTH * WORDS_PER_LINE,
  localparam int LADDR_W  = TAG_W + INDEX_W
) (
  input  logic                   clk_l1,
  input  logic                   rst_n,
  input  logic [DATA_LENGTH-1:0] alu_out,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [DATA_LENGTH-1:0] data_write,
  output logic [DATA_LENGTH-1:0] data_read,
  output logic                   DCC_halt,
  output logic                   data_update_req,
  output logic [DATA_LENGTH-1:0] alu_out_up,
  input  logic                   l2_update,
  input  logic [LINE_W-1:0]      l2_line,
  output logic                   dirty_req,
  output logic [LADDR_W-1:0]     dl1_dirty_addr,
  output logic [LINE_W-1:0]      dirty_data,
  input  logic                   dirty_ack
`ifdef DL1_SNOOP_INVALIDATE_EN
  ,
  input  logic                   replace_req,
  input  logic [LADDR_W-1:0]     replace_addr
`endif
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_REFILL    = 2'd2;

  logic [1:0]           r_state;
  logic [DL1_LINES-1:0] r_valid;
  logic [DL1_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [DL1_LINES];
  logic [LINE_W-1:0]    r_data [DL1_LINES];
  logic [INDEX_W-1:0]   r_wb_index;
  logic [LADDR_W-1:0]   r_refill_addr;

  logic [TAG_W-1:0]       w_tag;
  logic [INDEX_W-1:0]     w_index;
  logic [WORD_W-1:0]      w_word;
  logic                   w_unused_bits;
  logic                   w_req;
  logic                   w_hit;
  logic                   w_idle;
  logic                   w_store_hit;
  logic                   w_refill_done;
  logic [LINE_W-1:0]      w_cur_line;
  logic [LINE_W-1:0]      w_store_line;
  logic [DATA_LENGTH-1:0] w_cur_words [WORDS_PER_LINE];

  assign w_tag         = alu_out[DATA_LENGTH-1 -: TAG_W];
  assign w_index       = alu_out[OFFSET_W +: INDEX_W];
  assign w_word        = alu_out[2 +: WORD_W];
  assign w_unused_bits = ^alu_out[1:0];
  assign w_req         = cpu_read | cpu_write;
  assign w_idle        = (r_state == S_IDLE);
  assign w_cur_line    = r_data[w_index];

`ifdef DL1_SNOOP_INVALIDATE_EN
  logic [INDEX_W-1:0] w_snoop_index;
  logic [TAG_W-1:0]   w_snoop_tag;
  logic               w_snoop_match;
  logic               r_wb_snoop;

  assign w_snoop_index = replace_addr[INDEX_W-1:0];
  assign w_snoop_tag   = replace_addr[LADDR_W-1 -: TAG_W];
  assign w_snoop_match = replace_req && r_valid[w_snoop_index] && (r_tag[w_snoop_index] == w_snoop_tag);
  // A snoop on the CPU's line wins: the CPU access is forced to miss.
  assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag) &&
                 !(w_snoop_match && (w_snoop_index == w_index));
`else
  assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
`endif

  assign w_store_hit   = w_idle && cpu_write && w_hit && !rst_n;
  assign w_refill_done = (r_state == S_REFILL) && l2_update && !rst_n;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
      assign w_cur_words[gi] = w_cur_line[gi*DATA_LENGTH +: DATA_LENGTH];
      assign w_store_line[gi*DATA_LENGTH +: DATA_LENGTH] =
        (w_word == WORD_W'(gi)) ? data_write : w_cur_line[gi*DATA_LENGTH +: DATA_LENGTH];
    end
  endgenerate

  // Tag and data arrays are deliberately not reset; only valid/dirty are.
  always_ff @(posedge clk_l1) begin
    if (w_refill_done) begin
      r_data[r_refill_addr[INDEX_W-1:0]] <= l2_line;
      r_tag[r_refill_addr[INDEX_W-1:0]]  <= r_refill_addr[LADDR_W-1 -: TAG_W];
    end else if (w_store_hit) begin
      r_data[w_index] <= w_store_line;
    end
  end

  always_ff @(posedge clk_l1) begin
    if (rst_n) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_dirty       <= '0;
      r_wb_index    <= '0;
      r_refill_addr <= '0;
`ifdef DL1_SNOOP_INVALIDATE_EN
      r_wb_snoop    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_store_hit) r_dirty[w_index] <= 1'b1;
`ifdef DL1_SNOOP_INVALIDATE_EN
          if (w_snoop_match) begin
            if (r_dirty[w_snoop_index]) begin
              r_wb_index <= w_snoop_index;
              r_wb_snoop <= 1'b1;
              r_state    <= S_WRITEBACK;
            end else begin
              r_valid[w_snoop_index] <= 1'b0;
            end
          end else if (w_req && !w_hit) begin
            r_wb_snoop <= 1'b0;
`else
          if (w_req && !w_hit) begin
`endif
            r_wb_index    <= w_index;
            r_refill_addr <= {w_tag, w_index};
            r_state       <= (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (dirty_ack) begin
            r_dirty[r_wb_index] <= 1'b0;
`ifdef DL1_SNOOP_INVALIDATE_EN
            if (r_wb_snoop) begin
              r_valid[r_wb_index] <= 1'b0;
              r_state             <= S_IDLE;
            end else begin
              r_state <= S_REFILL;
            end
`else
            r_state <= S_REFILL;
`endif
          end
        end
        S_REFILL: begin
          if (l2_update) begin
            r_valid[r_refill_addr[INDEX_W-1:0]] <= 1'b1;
            r_dirty[r_refill_addr[INDEX_W-1:0]] <= 1'b0;
            r_state                             <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // All outputs are forced low while reset is asserted.
  always_comb begin
    data_read       = '0;
    DCC_halt        = 1'b0;
    data_update_req = 1'b0;
    alu_out_up      = '0;
    dirty_req       = 1'b0;
    dl1_dirty_addr  = '0;
    dirty_data      = '0;
    if (!rst_n) begin
      case (r_state)
        S_IDLE: begin
          DCC_halt = w_req && !w_hit;
          if (w_req && w_hit) data_read = w_cur_words[w_word];
        end
        S_WRITEBACK: begin
          DCC_halt       = 1'b1;
          dirty_req      = 1'b1;
          dl1_dirty_addr = {r_tag[r_wb_index], r_wb_index};
          dirty_data     = r_data[r_wb_index];
        end
        S_REFILL: begin
          DCC_halt        = 1'b1;
          data_update_req = 1'b1;
          alu_out_up      = {r_refill_addr, {OFFSET_W{1'b0}}};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dl1_data_cache.sv
// tb_dl1_data_cache: table vectors, hand sequences and random accesses against a memory-view model.
// Exercises the snoop port as well when DL1_SNOOP_INVALIDATE_EN is defined.
`timescale 1ns/1ps
module tb_dl1_data_cache;

  logic         clk_l1;
  logic         rst_n;
  logic [31:0]  alu_out;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  data_write;
  logic [31:0]  data_read;
  logic         DCC_halt;
  logic         data_update_req;
  logic [31:0]  alu_out_up;
  logic         l2_update;
  logic [127:0] l2_line;
  logic         dirty_req;
  logic [27:0]  dl1_dirty_addr;
  logic [127:0] dirty_data;
  logic         dirty_ack;
`ifdef DL1_SNOOP_INVALIDATE_EN
  logic         replace_req;
  logic [27:0]  replace_addr;
`endif

  dl1_data_cache dut (
    .clk_l1         (clk_l1),
    .rst_n          (rst_n),
    .alu_out        (alu_out),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .data_write     (data_write),
    .data_read      (data_read),
    .DCC_halt       (DCC_halt),
    .data_update_req(data_update_req),
    .alu_out_up     (alu_out_up),
    .l2_update      (l2_update),
    .l2_line        (l2_line),
    .dirty_req      (dirty_req),
    .dl1_dirty_addr (dl1_dirty_addr),
    .dirty_data     (dirty_data),
    .dirty_ack      (dirty_ack)
`ifdef DL1_SNOOP_INVALIDATE_EN
    ,
    .replace_req    (replace_req),
    .replace_addr   (replace_addr)
`endif
  );

  initial clk_l1 = 1'b0;
  always #5 clk_l1 = ~clk_l1;

  int n_cmp = 0;
  int n_err = 0;

  // Bench-side L2 contents and the architecturally visible memory (latest value of every word).
  logic [127:0] l2mem [logic [27:0]];
  logic [31:0]  view  [logic [29:0]];
  // Which line is resident at each index, and whether it holds unwritten-back data.
  bit           m_valid [64];
  bit           m_dirty [64];
  logic [21:0]  m_tag   [64];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_hit;
    bit          exp_wb;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'h1111_0000 ^ {a[31:2], 2'b00} ^ 32'h0000_0010;
  endfunction

  function automatic logic [31:0] view_get(input logic [31:0] a);
    if (view.exists(a[31:2])) return view[a[31:2]];
    return init_word(a);
  endfunction

  function automatic logic [127:0] view_line(input logic [27:0] la);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = view_get({la, w[1:0], 2'b00});
    return r;
  endfunction

  function automatic logic [127:0] l2_get(input logic [27:0] la);
    logic [127:0] r;
    if (l2mem.exists(la)) return l2mem[la];
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = init_word({la, w[1:0], 2'b00});
    return r;
  endfunction

  // Reset discards dirty lines, so their words revert to what L2 holds.
  function automatic void model_reset();
    logic [27:0]  la;
    logic [127:0] lw;
    for (int i = 0; i < 64; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        la = {m_tag[i], i[5:0]};
        lw = l2_get(la);
        for (int w = 0; w < 4; w++) view[{la, w[1:0]}] = lw[w*32 +: 32];
      end
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endfunction

  // One CPU access, acting as L2 while the DUT stalls. Delays < 0 are randomized.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wb_d, input int rf_d,
                        output bit stalled, output bit wb_seen, output logic [31:0] rdata);
    logic [5:0]   idx;
    logic [21:0]  tag;
    logic [27:0]  victim;
    logic [127:0] vline;
    bit           hit, exp_wb, rf_seen;
    int           cycles, wb_wait, rf_wait, exp_cycles;
    idx     = addr[9:4];
    tag     = addr[31:10];
    hit     = m_valid[idx] && (m_tag[idx] == tag);
    exp_wb  = !hit && m_valid[idx] && m_dirty[idx];
    victim  = {m_tag[idx], idx};
    vline   = view_line(victim);
    wb_wait = (wb_d < 0) ? int'($urandom_range(0, 3)) : wb_d;
    rf_wait = (rf_d < 0) ? int'($urandom_range(0, 3)) : rf_d;
    exp_cycles = hit ? 0 : (2 + rf_wait + (exp_wb ? wb_wait + 1 : 0));
    alu_out    = addr;
    cpu_read   = rd;
    cpu_write  = wr;
    data_write = wdata;
    cycles  = 0;
    wb_seen = 1'b0;
    rf_seen = 1'b0;
    @(negedge clk_l1);
    while (DCC_halt && cycles < 60) begin
      if (dirty_req) begin
        wb_seen = 1'b1;
        chk("wb_addr", 128'(dl1_dirty_addr), 128'(victim));
        chk("wb_data", dirty_data, vline);
        if (wb_wait == 0) begin
          l2mem[dl1_dirty_addr] = dirty_data;
          dirty_ack = 1'b1;
        end else begin
          wb_wait--;
        end
      end
      if (data_update_req) begin
        if (!rf_seen) chk("refill_addr", 128'(alu_out_up), 128'({addr[31:4], 4'h0}));
        rf_seen = 1'b1;
        if (rf_wait == 0) begin
          l2_line   = l2_get(addr[31:4]);
          l2_update = 1'b1;
        end else begin
          rf_wait--;
        end
      end
      @(posedge clk_l1);
      #1;
      dirty_ack = 1'b0;
      l2_update = 1'b0;
      @(negedge clk_l1);
      cycles++;
    end
    if (cycles >= 60) chk("halt_timeout", 128'(DCC_halt), 128'(0));
    stalled = (cycles != 0);
    rdata   = data_read;
    chk("stall_cycles", 128'(cycles), 128'(exp_cycles));
    chk("writeback_seen", 128'(wb_seen), 128'(exp_wb));
    if (rd && !wr) chk("read_data", 128'(data_read), 128'(view_get(addr)));
    $display("txn rd=%0b wr=%0b addr=%08h wdata=%08h rdata=%08h stall=%0d wb=%0b",
             rd, wr, addr, wdata, data_read, cycles, wb_seen);
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      view[addr[31:2]] = wdata;
      m_dirty[idx]     = 1'b1;
    end
    @(posedge clk_l1);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          st, wbs, rd, wr;
    logic [31:0] rdat, addr;
    int          kind;

    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'h1111_0000};
    vecs[1] = '{1'b1, 32'h0000_0040, 32'h0000_0567, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0040, 32'h0,         1'b1, 1'b0, 32'h0000_0567};
    vecs[3] = '{1'b0, 32'h0000_0044, 32'h0,         1'b1, 1'b0, 32'h1111_0054};
    vecs[4] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 32'h0000_0440, 32'h0,         1'b0, 1'b1, 32'h1111_0450};
    vecs[7] = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 1'b0, 32'h0000_0567};
    vecs[8] = '{1'b0, 32'h0000_0410, 32'h0,         1'b0, 1'b1, 32'h1111_0400};
    vecs[9] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF};

    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end

    // Reset with a request pending: every output must stay low.
    rst_n      = 1'b1;
    alu_out    = 32'h0000_0010;
    cpu_read   = 1'b1;
    cpu_write  = 1'b0;
    data_write = '0;
    l2_update  = 1'b0;
    l2_line    = '0;
    dirty_ack  = 1'b0;
`ifdef DL1_SNOOP_INVALIDATE_EN
    replace_req  = 1'b0;
    replace_addr = '0;
`endif
    repeat (3) @(posedge clk_l1);
    @(negedge clk_l1);
    chk("rst_halt", 128'(DCC_halt), 128'(0));
    chk("rst_update_req", 128'(data_update_req), 128'(0));
    chk("rst_dirty_req", 128'(dirty_req), 128'(0));
    chk("rst_alu_out_up", 128'(alu_out_up), 128'(0));
    chk("rst_dirty_addr", 128'(dl1_dirty_addr), 128'(0));
    chk("rst_dirty_data", dirty_data, 128'(0));
    chk("rst_data_read", 128'(data_read), 128'(0));
    @(posedge clk_l1);
    #1;
    rst_n    = 1'b0;
    cpu_read = 1'b0;
    @(negedge clk_l1);
    chk("idle_halt", 128'(DCC_halt), 128'(0));
    @(posedge clk_l1);
    #1;

    // Table vectors: fixed 3-cycle dirty_ack hold and 1-cycle refill wait.
    for (int i = 0; i < 10; i++) begin
      access(!vecs[i].wr, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 3, 1, st, wbs, rdat);
      chk($sformatf("vec%0d_hit", i), 128'(!st), 128'(vecs[i].exp_hit));
      chk($sformatf("vec%0d_wb", i), 128'(wbs), 128'(vecs[i].exp_wb));
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), 128'(rdat), 128'(vecs[i].exp_rdata));
    end

    // Read and write together on a resident line behave as a store without stalling.
    access(1'b1, 1'b1, 32'h0000_0048, 32'h0BAD_F00D, -1, -1, st, wbs, rdat);
    chk("rw_both_no_stall", 128'(st), 128'(0));
    access(1'b1, 1'b0, 32'h0000_0048, 32'h0, -1, -1, st, wbs, rdat);
    chk("rw_both_stored", 128'(rdat), 128'(32'h0BAD_F00D));

    // Stray l2_update / dirty_ack while idle must not touch the cache.
    l2_update = 1'b1;
    l2_line   = '1;
    dirty_ack = 1'b1;
    @(negedge clk_l1);
    chk("stray_halt", 128'(DCC_halt), 128'(0));
    @(posedge clk_l1);
    #1;
    l2_update = 1'b0;
    dirty_ack = 1'b0;
    access(1'b1, 1'b0, 32'h0000_0048, 32'h0, -1, -1, st, wbs, rdat);
    chk("stray_ignored", 128'(rdat), 128'(32'h0BAD_F00D));

    // Random accesses over a few conflicting tags on four indices.
    for (int t = 0; t < 250; t++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        @(negedge clk_l1);
        chk("rand_idle_halt", 128'(DCC_halt), 128'(0));
        chk("rand_idle_reqs", 128'({dirty_req, data_update_req}), 128'(0));
        @(posedge clk_l1);
        #1;
      end else begin
        addr = {20'h0, 2'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
        rd   = (kind < 6);
        wr   = (kind >= 5);
        access(rd, wr, addr, $urandom, -1, -1, st, wbs, rdat);
      end
    end

    // Reset while refilling aborts the miss.
    alu_out  = 32'h0000_1F00;
    cpu_read = 1'b1;
    kind     = 0;
    @(negedge clk_l1);
    while (!data_update_req && kind < 10) begin
      @(negedge clk_l1);
      kind++;
    end
    chk("reach_refill", 128'(data_update_req), 128'(1));
    rst_n = 1'b1;
    @(posedge clk_l1);
    #1;
    @(negedge clk_l1);
    chk("rst_refill_update_req", 128'(data_update_req), 128'(0));
    chk("rst_refill_halt", 128'(DCC_halt), 128'(0));
    @(posedge clk_l1);
    #1;
    rst_n    = 1'b0;
    cpu_read = 1'b0;
    @(negedge clk_l1);
    chk("post_rst_update_req", 128'(data_update_req), 128'(0));
    chk("post_rst_halt", 128'(DCC_halt), 128'(0));
    @(posedge clk_l1);
    #1;
    model_reset();
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, -1, -1, st, wbs, rdat);
    chk("post_rst_miss", 128'(st), 128'(1));

`ifdef DL1_SNOOP_INVALIDATE_EN
    // Snoop of a clean resident line invalidates it.
    replace_req  = 1'b1;
    replace_addr = 28'h000_0001;
    @(negedge clk_l1);
    chk("snoop_clean_halt", 128'(DCC_halt), 128'(0));
    @(posedge clk_l1);
    #1;
    replace_req  = 1'b0;
    m_valid[1]   = 1'b0;
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, -1, -1, st, wbs, rdat);
    chk("snoop_clean_miss", 128'(st), 128'(1));
    // Snoop of a dirty line writes it back first, then invalidates it.
    access(1'b0, 1'b1, 32'h0000_0010, 32'h0000_1234, -1, -1, st, wbs, rdat);
    replace_req = 1'b1;
    @(posedge clk_l1);
    #1;
    replace_req = 1'b0;
    @(negedge clk_l1);
    chk("snoop_dirty_req", 128'(dirty_req), 128'(1));
    chk("snoop_dirty_addr", 128'(dl1_dirty_addr), 128'(28'h000_0001));
    chk("snoop_dirty_word0", 128'(dirty_data[31:0]), 128'(32'h0000_1234));
    l2mem[dl1_dirty_addr] = dirty_data;
    dirty_ack = 1'b1;
    @(posedge clk_l1);
    #1;
    dirty_ack = 1'b0;
    @(negedge clk_l1);
    chk("snoop_dirty_done", 128'({dirty_req, DCC_halt}), 128'(0));
    @(posedge clk_l1);
    #1;
    m_valid[1] = 1'b0;
    m_dirty[1] = 1'b0;
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, -1, -1, st, wbs, rdat);
    chk("snoop_dirty_miss", 128'(st), 128'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
